add_serial_arb: RTL and testbench

ADD_SERIAL_ARB -- requirements
Module: add_serial_arb

---
 rtl/add_serial_arb.sv | 162 ++++++++++++++++
 tb/tb_add_serial_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/add_serial_arb.sv
// -----------------------------------------------------------------------------
// add_serial_arb
//   Two-requester, bit-serial adder. An arbiter picks one requester (round-robin
//   on a tie), captures its operands and then adds them one bit per clock,
//   LSB first. The result is presented with a single-cycle valid pulse.
//
// Ports
//   clk            : clock, all state changes on its rising edge
//   rst_n          : asynchronous active-low reset
//   req0, req1     : requester 0/1 asks for one addition
//   a0, b0, a1, b1 : operands of requester 0/1 (WIDTH bits)
//   gnt0, gnt1     : one-cycle grant, high the cycle after the operands were captured
//   busy           : high whenever the engine is not idle
//   sum            : result of the last completed addition (modulo 2^WIDTH)
//   cout           : carry-out of the last completed addition
//   owner          : requester index of the captured/completed operation
//   valid          : one-cycle pulse, sum/cout/owner carry a new result
// -----------------------------------------------------------------------------
module add_serial_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             owner,
  output logic             valid
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;

  logic             win;
  logic             s_bit;
  logic             carry_nxt;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // One full-adder slice working on the current LSBs of the shift registers.
  assign s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = maj3(a_q[0], b_q[0], carry_q);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    count_d      = count_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    win          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // On a tie the requester that was not served last wins.
          win          = (req0 & req1) ? ~last_owner_q : req1;
          a_d          = win ? a1 : a0;
          b_d          = win ? b1 : b0;
          sum_d        = '0;
          count_d      = '0;
          carry_d      = 1'b0;
          owner_d      = win;
          last_owner_d = win;
          gnt0_d       = ~win;
          gnt1_d       = win;
          state_d      = S_ADD;
        end
      end
      S_ADD: begin
        // Result bits enter at the MSB so that after WIDTH shifts the first
        // (least significant) bit has arrived at position 0.
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_BIT) begin
          cout_d  = carry_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      count_q      <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      owner_q      <= 1'b0;
      // Starting from 1 makes requester 0 win the first tie after reset.
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      carry_q      <= carry_d;
      cout_q       <= cout_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = (state_q != S_IDLE);
  assign valid = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_add_serial_arb.sv
module tb_add_serial_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, cout, owner, valid;
  logic [7:0] sum;

  // Narrow instance for the 4-bit build.
  logic       c_req0, c_req1;
  logic [3:0] c_a0, c_b0, c_a1, c_b1;
  logic       c_gnt0, c_gnt1, c_busy, c_cout, c_owner, c_valid;
  logic [3:0] c_sum;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  add_serial_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .sum(sum),
    .cout(cout), .owner(owner), .valid(valid)
  );

  add_serial_arb #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req0(c_req0), .req1(c_req1),
    .a0(c_a0), .b0(c_b0), .a1(c_a1), .b1(c_b1),
    .gnt0(c_gnt0), .gnt1(c_gnt1), .busy(c_busy), .sum(c_sum),
    .cout(c_cout), .owner(c_owner), .valid(c_valid)
  );

  typedef struct {
    logic       r0, r1;
    logic [7:0] a0, b0, a1, b1;
    logic [7:0] es;
    logic       ec, eo;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge with the engine idle. Drops the winner's request
  // after its grant unless hold is set, and scrambles the winner's operands
  // during the addition to show they no longer matter.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [7:0] xa0, input logic [7:0] xb0,
                         input logic [7:0] xa1, input logic [7:0] xb1,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input bit hold);
    int k;
    req0 = r0; req1 = r1; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    @(negedge clk);
    k = 1;
    while (!(gnt0 || gnt1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("gnt_wait", k, 1);
    chk("gnt_who", {gnt1, gnt0}, eo ? 2 : 1);
    chk("busy_at_gnt", busy, 1);
    if (eo) begin
      if (!hold) req1 = 1'b0;
      a1 = 8'($urandom); b1 = 8'($urandom);
    end else begin
      if (!hold) req0 = 1'b0;
      a0 = 8'($urandom); b0 = 8'($urandom);
    end
    @(negedge clk);
    k = 1;
    chk("gnt_one_cycle", {gnt1, gnt0}, 0);
    while (!valid && k < 40) begin
      @(negedge clk);
      k++;
      if (!hold) begin
        a0 = 8'($urandom); b0 = 8'($urandom);
      end
    end
    chk("latency", k, 8);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("owner", owner, eo);
    chk("busy_at_valid", busy, 1);
    @(negedge clk);
    chk("valid_pulse", valid, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int k;
    int seen;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    c_req0 = 0; c_req1 = 0; c_a0 = 0; c_b0 = 0; c_a1 = 0; c_b1 = 0;
    rst_n = 1'b0;

    vt[0] = '{1'b1, 1'b0, 8'h35, 8'h4A, 8'h00, 8'h00, 8'h7F, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFE, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b1, 8'h10, 8'h20, 8'h80, 8'h80, 8'h30, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie right after reset favours requester 0; requester 1 keeps asking and
    // is captured at the earliest possible edge; a repeated tie goes back to 0.
    run_txn(1, 1, 8'h10, 8'h20, 8'h80, 8'h80, 8'h30, 1'b0, 1'b0, 1'b0);
    run_txn(0, 1, 8'h00, 8'h00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
    run_txn(1, 1, 8'h10, 8'h20, 8'h80, 8'h80, 8'h30, 1'b0, 1'b0, 1'b0);
    req0 = 0; req1 = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i].r0, vt[i].r1, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1,
              vt[i].es, vt[i].ec, vt[i].eo, 1'b0);
      req0 = 0; req1 = 0;
    end

    // req0 held throughout: grants come back to back, each result uses only
    // the operands present at its capture edge.
    run_txn(1, 0, 8'h21, 8'h13, 8'h00, 8'h00, 8'h34, 1'b0, 1'b0, 1'b1);
    run_txn(1, 0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h40, 1'b1, 1'b0, 1'b1);
    req0 = 0;
    @(negedge clk);

    // Reset in the middle of an addition.
    req1 = 1; a1 = 8'hFF; b1 = 8'hFF;
    @(negedge clk);
    chk("abort_gnt", gnt1, 1);
    req1 = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run_txn(0, 1, 8'h00, 8'h00, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b1, 1'b0);
    req1 = 0;

    // 4-bit build: 0x9 + 0x8 = 0x11.
    c_req0 = 1; c_a0 = 4'h9; c_b0 = 4'h8;
    @(negedge clk);
    k = 1;
    while (!c_gnt0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("w4_gnt_wait", k, 1);
    chk("w4_gnt1", c_gnt1, 0);
    c_req0 = 0; c_a0 = 4'h0; c_b0 = 4'h0;
    k = 0;
    while (!c_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("w4_latency", k, 4);
    chk("w4_sum", c_sum, 1);
    chk("w4_cout", c_cout, 1);
    chk("w4_owner", c_owner, 0);
    chk("w4_busy", c_busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
